apu_reg_loader: RTL and testbench

APU_REG_LOADER -- requirements
Module: apu_reg_loader

---
 rtl/apu_reg_loader.sv | 173 +++++++++++++++++
 tb/tb_apu_reg_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/apu_reg_loader.sv
// apu_reg_loader
// Turns a two-byte serial framing protocol into APU register writes.
//   Header byte: bit7=1, bit6=data[7], bit5=0, bits4:0=register offset.
//   Data byte  : bit7=0, bits6:0=data[6:0].
// Completed frames are queued in a small FIFO and presented on a
// valid/ready write port toward the APU register file.
//
// Ports
//   clk        in   system clock (single clock domain)
//   rst        in   asynchronous active-high reset
//   rx_data    in   [7:0] received byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe per received byte
//   wr_ready   in   register file accepts the head write this cycle
//   wr_valid   out  FIFO non-empty, head write presented
//   wr_addr    out  [4:0] register offset 0x00-0x17
//   wr_data    out  [7:0] register data
//   link       out  activity indicator, held LINK_HOLD cycles per frame
//   frame_err  out  sticky framing/protocol error
//   overflow   out  sticky FIFO overflow
//   clr_err    in   synchronous clear of both sticky flags
module apu_reg_loader #(
  parameter int TIMEOUT   = 12_000,
  parameter int LINK_HOLD = 1_200_000,
  parameter int DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       wr_ready,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       link,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LINK_HOLD + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_LOAD = LW'(LINK_HOLD);

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  function automatic logic hdr_ok(input logic [7:0] b);
    return (b[5] == 1'b0) && (b[4:0] <= 5'h17);
  endfunction

  state_t        state;
  logic [4:0]    addr_q;
  logic          d7_q;
  logic [TW-1:0] tmo_cnt;
  logic [LW-1:0] link_cnt;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic push_req, err_evt;
  logic full, pop, do_push, ovf_evt;
  logic [12:0] push_word;

  // Parser decode: which byte events complete a frame or signal an error.
  always_comb begin
    push_req = 1'b0;
    err_evt  = 1'b0;
    if (rx_valid) begin
      if (rx_data[7]) begin
        // A header while waiting abandons the pending frame.
        if (state == WAIT_DATA || !hdr_ok(rx_data)) err_evt = 1'b1;
      end else begin
        if (state == WAIT_DATA) push_req = 1'b1;
        else                    err_evt  = 1'b1;
      end
    end else if (state == WAIT_DATA && tmo_cnt == TMO_LAST) begin
      err_evt = 1'b1;
    end
  end

  assign full      = (count == DEPTH_C);
  assign wr_valid  = (count != '0);
  assign pop       = wr_valid & wr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push_req & (~full | pop);
  assign ovf_evt   = push_req & full & ~pop;
  assign push_word = {addr_q, d7_q, rx_data[6:0]};

  // Head is gated so the port reads zero while empty and after reset.
  assign wr_addr = wr_valid ? mem[rptr][12:8] : 5'd0;
  assign wr_data = wr_valid ? mem[rptr][7:0]  : 8'd0;

  // Parser state and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 5'd0;
      d7_q    <= 1'b0;
      tmo_cnt <= '0;
    end else if (rx_valid) begin
      if (rx_data[7]) begin
        if (hdr_ok(rx_data)) begin
          addr_q  <= rx_data[4:0];
          d7_q    <= rx_data[6];
          tmo_cnt <= '0;
          state   <= WAIT_DATA;
        end else begin
          state <= IDLE;
        end
      end else begin
        state <= IDLE;
      end
    end else if (state == WAIT_DATA) begin
      if (tmo_cnt == TMO_LAST) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // FIFO storage (data path, not reset)
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags and link indicator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      link      <= 1'b0;
      link_cnt  <= '0;
    end else begin
      if (err_evt)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovf_evt)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
      // Every completed frame refreshes the LED, even one lost to overflow.
      if (push_req) begin
        link_cnt <= LINK_LOAD;
        link     <= 1'b1;
      end else if (link_cnt != '0) begin
        link_cnt <= link_cnt - 1'b1;
        link     <= (link_cnt > LW'(1));
      end
    end
  end

endmodule

// File: tb/tb_apu_reg_loader.sv
// Directed bench for apu_reg_loader with small TIMEOUT/LINK_HOLD values.
module tb_apu_reg_loader;

  localparam int TIMEOUT   = 8;
  localparam int LINK_HOLD = 5;
  localparam int DEPTH     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_ready;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       link;
  logic       frame_err;
  logic       overflow;
  logic       clr_err;

  int n_chk  = 0;
  int n_pass = 0;
  int nwr    = 0;
  int base;

  apu_reg_loader #(
    .TIMEOUT(TIMEOUT), .LINK_HOLD(LINK_HOLD), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .link(link), .frame_err(frame_err),
    .overflow(overflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Count writes actually accepted by the register file.
  always @(posedge clk) if (!rst && wr_valid && wr_ready) nwr++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; wr_ready = 1'b1; clr_err = 1'b0;
    idle(3);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_link", link, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    idle(2);

    // Single frame: 0xC8 0x3F -> addr 0x08, data 0xBF
    send(8'hC8);
    send(8'h3F);
    chk("single_valid", wr_valid, 1);
    chk("single_addr", wr_addr, 5'h08);
    chk("single_data", wr_data, 8'hBF);
    chk("single_link", link, 1);
    chk("single_ferr", frame_err, 0);
    @(negedge clk);
    chk("single_one_cycle", wr_valid, 0);
    chk("single_nwr", nwr, 1);
    idle(LINK_HOLD + 1);
    chk("link_fall", link, 0);

    // Overflow: five frames with the register file stalled
    wr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'h80 | 8'(i));
      send(8'(8'h11 * i));
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_ferr", frame_err, 0);
    chk("ovf_head_stable", wr_addr, 5'h01);
    idle(2);
    chk("ovf_head_hold", wr_data, 8'h11);
    base = nwr;
    wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", wr_valid, 1);
      chk("drain_addr", wr_addr, 5'(i));
      chk("drain_data", wr_data, 8'(8'h11 * i));
      @(negedge clk);
    end
    chk("drain_empty", wr_valid, 0);
    chk("drain_count", nwr - base, 4);
    clear_flags();
    chk("ovf_clr", overflow, 0);

    // Timeout: header 0x85 then silence, then stray data 0x12
    base = nwr;
    send(8'h85);
    chk("tmo_pending_ok", frame_err, 0);
    idle(TIMEOUT + 2);
    chk("tmo_ferr", frame_err, 1);
    send(8'h12);
    chk("tmo_no_valid", wr_valid, 0);
    idle(2);
    chk("tmo_no_write", nwr - base, 0);
    clear_flags();

    // Header replaces pending header: 0x81 0x82 0x55
    base = nwr;
    send(8'h81);
    send(8'h82);
    send(8'h55);
    chk("dbl_ferr", frame_err, 1);
    chk("dbl_valid", wr_valid, 1);
    chk("dbl_addr", wr_addr, 5'h02);
    chk("dbl_data", wr_data, 8'h55);
    idle(2);
    chk("dbl_nwr", nwr - base, 1);
    clear_flags();
    chk("dbl_clr", frame_err, 0);

    // Illegal headers
    base = nwr;
    send(8'h98);
    chk("bad_addr_ferr", frame_err, 1);
    clear_flags();
    chk("bad_addr_clr", frame_err, 0);
    send(8'hA0);
    chk("bad_bit5_ferr", frame_err, 1);
    clear_flags();
    send(8'h3F);
    chk("bad_data_idle", frame_err, 1);
    idle(2);
    chk("bad_no_write", nwr - base, 0);
    // Clear and a new error in the same cycle: error wins
    clr_err = 1'b1;
    send(8'hA0);
    clr_err = 1'b0;
    chk("clr_vs_err", frame_err, 1);

    // Reset in the middle of a frame
    wr_ready = 1'b0;
    send(8'h84);
    send(8'h07);
    chk("pre_rst_valid", wr_valid, 1);
    send(8'h83);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", wr_valid, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_data", wr_data, 0);
    chk("arst_link", link, 0);
    chk("arst_ferr", frame_err, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_ready = 1'b1;
    base = nwr;
    @(negedge clk);
    send(8'h01);
    chk("post_rst_ferr", frame_err, 1);
    chk("post_rst_valid", wr_valid, 0);
    idle(2);
    chk("post_rst_nwr", nwr - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
